// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  // Control states of the serial subtractor
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_t;

  // Default operand/result width
  localparam int DEFAULT_N = 4;

  // Bit-counter width for an N-bit operation; never narrower than one bit
  function automatic int cnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow-out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow generated/propagated by this bit position
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, one bit per clock, LSB
// first, using a single full-subtractor cell and a registered borrow.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         overflow
);

  localparam int CW = cnt_width(N);

  sub_state_t   state_reg, state_next;

  logic [N-1:0]  sa_reg;      // minuend, shifted right each SHIFT cycle
  logic [N-1:0]  sb_reg;      // subtrahend, shifted right each SHIFT cycle
  logic [N-1:0]  res_reg;     // result bits enter at the MSB
  logic          br_reg;      // running borrow between bit positions
  logic          a_msb_reg;   // operand sign bits kept for overflow
  logic          b_msb_reg;
  logic [CW-1:0] cnt_reg;     // index of the bit being processed

  logic [N-1:0]  diff_reg;    // published results, held between operations
  logic          bout_reg;
  logic          ovf_reg;

  logic          cell_d;
  logic          cell_b;
  logic          last_bit;

  full_subtractor u_cell (
    .x    (sa_reg[0]),
    .y    (sb_reg[0]),
    .bin  (br_reg),
    .d    (cell_d),
    .bout (cell_b)
  );

  assign last_bit = (cnt_reg == CW'(N - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture, bit-serial shifting and result publication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sa_reg    <= '0;
      sb_reg    <= '0;
      res_reg   <= '0;
      br_reg    <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      cnt_reg   <= '0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            br_reg    <= bin;
            a_msb_reg <= a[N-1];
            b_msb_reg <= b[N-1];
            cnt_reg   <= '0;
            res_reg   <= '0;
          end
        end
        SHIFT: begin
          res_reg <= {cell_d, res_reg[N-1:1]};
          sa_reg  <= {1'b0, sa_reg[N-1:1]};
          sb_reg  <= {1'b0, sb_reg[N-1:1]};
          br_reg  <= cell_b;
          cnt_reg <= cnt_reg + CW'(1);
          // Publish on the final bit so results are valid during DONE and
          // stay put through the following operation until its own DONE.
          if (last_bit) begin
            diff_reg <= {cell_d, res_reg[N-1:1]};
            bout_reg <= cell_b;
            ovf_reg  <= (a_msb_reg != b_msb_reg) && (cell_d != a_msb_reg);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign diff     = diff_reg;
  assign bout     = bout_reg;
  assign overflow = ovf_reg;

endmodule
